// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser (start, 8 data LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int BAUD_CNT_MAX = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       valid_flag,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       drop_flag
);

  localparam int                CNT_W     = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic              push;
  logic              pop;
  logic [7:0]        head;

  // Serialiser
  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              baud_done;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign head      = mem[rd_ptr];
  assign baud_done = (baud_cnt == CNT_LAST);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    push       = valid_flag && !full;
    pop        = (count != '0) && ((state == IDLE) || (state == STOP && baud_done));
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + (ADDR_W + 1)'(1);
      2'b01:   count_next = count - (ADDR_W + 1)'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: storage carries no reset; pointers and count define which entries are valid.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count     <= count_next;
      full      <= (count_next == DEPTH_CNT);
      // full is sampled before the edge, so a write while full is dropped even if a pop happens now
      drop_flag <= valid_flag && full;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          if (pop) begin
            shift <= head;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end

        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              // chain straight into the next frame with no idle gap
              shift <= head;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^head;
`endif
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: cycle-accurate line/flag model built from frame timing arithmetic,
// plus an independent mid-bit sampling decoder that recovers the transmitted bytes.
module tb_uart_tx_fifo;

  localparam int N     = 16;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int BITS  = 11;
`else
  localparam int BITS  = 10;
`endif
  localparam int F     = BITS * N;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b1;
  logic       valid_flag = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, busy, full, drop_flag;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_got[$];
  int         cyc = 0;
  int         frame_start = 0;
  int         frame_end = 0;
  logic [7:0] cur = 8'h00;
  logic       exp_drop = 1'b0;

  // Decoder state
  logic       dec_on = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;

  always #5 sys_clk = ~sys_clk;

  uart_tx_fifo #(
    .BAUD_CNT_MAX(N),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_W      (3)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .valid_flag(valid_flag),
    .data_in   (data_in),
    .tx        (tx),
    .busy      (busy),
    .full      (full),
    .drop_flag (drop_flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic void model_reset();
    if (cyc < frame_end) void'(exp_rx.pop_back());
    q.delete();
    frame_end = cyc;
    exp_drop  = 1'b0;
  endfunction

  function automatic void model_edge(input logic v, input logic [7:0] d);
    logic full_pre;
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      full_pre = (q.size() == DEPTH);
      if (q.size() != 0 && cyc >= frame_end) begin
        cur         = q.pop_front();
        frame_start = cyc;
        frame_end   = cyc + F;
        exp_rx.push_back(cur);
      end
      if (v && !full_pre) q.push_back(d);
      exp_drop = v && full_pre;
    end
  endfunction

  task automatic step(input logic v, input logic [7:0] d);
    logic exp_busy, exp_tx;
    valid_flag = v;
    data_in    = d;
    @(posedge sys_clk);
    model_edge(v, d);
    #1;
    exp_busy = (cyc < frame_end);
    exp_tx   = exp_busy ? frame_bit(cur, (cyc - frame_start) / N) : 1'b1;
    check($sformatf("tx@%0d", cyc), tx, exp_tx);
    check($sformatf("busy@%0d", cyc), busy, exp_busy);
    check($sformatf("full@%0d", cyc), full, q.size() == DEPTH);
    check($sformatf("drop@%0d", cyc), drop_flag, exp_drop);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || cyc < frame_end) && n < 20 * F) begin
      step(1'b0, 8'h00);
      n++;
    end
    repeat (4) step(1'b0, 8'h00);
  endtask

  // Independent decoder: samples the line at each bit centre
  initial begin
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        dec_on = 1'b0;
      end else if (!dec_on) begin
        if (tx == 1'b0) begin
          dec_on  = 1'b1;
          dec_cnt = 0;
        end
      end else begin
        dec_cnt++;
        if (dec_cnt % N == N / 2) begin
          if (dec_cnt / N == 0) check("dec_start", tx, 1'b0);
          else if (dec_cnt / N <= 8) dec_byte[dec_cnt / N - 1] = tx;
`ifdef UART_TX_PARITY_EN
          else if (dec_cnt / N == 9) check("dec_parity", tx, ^dec_byte);
`endif
          if (dec_cnt / N == BITS - 1) begin
            check("dec_stop", tx, 1'b1);
            rx_got.push_back(dec_byte);
            dec_on = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_drop", drop_flag, 1'b0);
    repeat (3) step(1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (5) step(1'b0, 8'h00);

    // Single byte, then the bit-order pattern
    step(1'b1, 8'h00);
    drain();
    step(1'b1, 8'h58);
    drain();

    // Back-to-back frames with no gap
    step(1'b1, 8'h07);
    step(1'b1, 8'h0F);
    step(1'b1, 8'hBD);
    drain();

    // Overflow: ten consecutive writes, the tenth is dropped
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i));
    drain();

    // Randomised traffic, dense enough to hit full and drops
    repeat (1500) step($urandom_range(0, 9) == 0, 8'($urandom));
    drain();

    // Reset in data bit 3 of the first of three queued frames
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    step(1'b1, 8'hF0);
    while (cyc < frame_start + 4 * N + N / 2) step(1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_full", full, 1'b0);
    model_reset();
    repeat (2) step(1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (3 * N) step(1'b0, 8'h00);

    // Transmitter still works after the reset
    step(1'b1, 8'hC3);
    drain();

    check("rx_count", rx_got.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++)
      check($sformatf("rx_byte[%0d]", i), rx_got[i], exp_rx[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
